// File: rtl/cache_tgen_pkg.sv
// Shared types and constants for the cache traffic generator and its divider.
package cache_tgen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DIVIDE,
        DONE
    } state_e;

    localparam logic [1:0] MODE_SEQ    = 2'd0;
    localparam logic [1:0] MODE_STRIDE = 2'd1;
    localparam logic [1:0] MODE_RAND   = 2'd2;

    localparam int PERCENT = 100;
    localparam int RATE_W  = 7;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, DVD_W cycles from start.
// done_o pulses for one cycle when quotient_o is valid; quotient_o keeps the low QUO_W bits.
module seq_divider #(
    parameter int DVD_W = 21,
    parameter int DSR_W = 14,
    parameter int QUO_W = DVD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DSR_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [QUO_W-1:0] quotient_o
);

    localparam int CNT_BITS = $clog2(DVD_W + 1);

    logic [DSR_W-1:0]    rem_q, rem_d, rem_src;
    logic [DVD_W-1:0]    dvd_q, dvd_d, dvd_src;
    logic [DSR_W-1:0]    dsr_q, dsr_src;
    logic [QUO_W-1:0]    quo_q, quo_d, quo_src;
    logic [CNT_BITS-1:0] cnt_q;
    logic                busy_q, done_q;
    logic [DSR_W:0]      trial;
    logic                fits;

    // The load cycle performs the first iteration on the fresh operands.
    always_comb begin
        rem_src = start_i ? '0 : rem_q;
        dvd_src = start_i ? dividend_i : dvd_q;
        dsr_src = start_i ? divisor_i : dsr_q;
        quo_src = start_i ? '0 : quo_q;
        trial   = {rem_src, dvd_src[DVD_W-1]};
        fits    = trial >= {1'b0, dsr_src};
        rem_d   = fits ? DSR_W'(trial - {1'b0, dsr_src}) : DSR_W'(trial);
        quo_d   = QUO_W'({quo_src, fits});
        dvd_d   = DVD_W'({dvd_src, 1'b0});
    end

    // NOTE: every register, datapath included, takes the async reset so an aborted run leaves no stale quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= divisor_i;
            quo_q  <= quo_d;
            cnt_q  <= CNT_BITS'(DVD_W - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_BITS'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/cache_traffic_gen.sv
// Access-pattern generator for cache hit-rate runs: sequential, strided or LFSR traffic,
// then a hit-rate percentage. Define CACHE_TGEN_WRITE_MIX_EN to make every WRITE_EVERY-th access a write.
module cache_traffic_gen
    import cache_tgen_pkg::*;
#(
    parameter int               ADDR_W      = 15,
    parameter int               CNT_W       = 14,
    parameter logic [ADDR_W-1:0] LFSR_TAPS  = 15'h6000,
    parameter int               WRITE_EVERY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  num_accesses,
    input  logic              cache_ready,
    input  logic              cache_hit,
    output logic              cache_read,
    output logic              cache_write,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  attempts,
    output logic [CNT_W-1:0]  hits,
    output logic [6:0]        hit_rate
);

    localparam int DVD_W = CNT_W + 7;

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   stride_q, addr_q, addr_d;
    logic [CNT_W-1:0]    num_q, attempts_q, hits_q, hits_inc;
    logic [RATE_W-1:0]   hit_rate_q;
    logic                read_q, busy_q, done_q;
    logic                last_access, div_start, div_busy, div_done;
    logic [RATE_W-1:0]   div_quo;

`ifdef CACHE_TGEN_WRITE_MIX_EN
    localparam int               PH_W    = $clog2(WRITE_EVERY);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(WRITE_EVERY - 1);
    logic [PH_W-1:0] phase_q, phase_d;
    logic            write_q;
    assign phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    assign cache_write = write_q;
`else
    assign cache_write = 1'b0;
`endif

    always_comb begin
        case (mode_q)
            MODE_STRIDE: addr_d = addr_q + stride_q;
            MODE_RAND:   addr_d = (addr_q >> 1) ^ (addr_q[0] ? LFSR_TAPS : '0);
            default:     addr_d = addr_q + 1'b1;
        endcase
    end

    assign hits_inc    = hits_q + CNT_W'(cache_hit);
    assign last_access = (attempts_q + 1'b1) == num_q;
    // Divider loads next-cycle counter values on the completing edge so DIVIDE lasts exactly DVD_W cycles.
    assign div_start   = (state_q == ISSUE) && cache_ready && last_access && !div_busy;

    seq_divider #(
        .DVD_W (DVD_W),
        .DSR_W (CNT_W),
        .QUO_W (RATE_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (DVD_W'(hits_inc) * DVD_W'(PERCENT)),
        .divisor_i  (attempts_q + 1'b1),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_SEQ;
            stride_q   <= '0;
            num_q      <= '0;
            addr_q     <= '0;
            attempts_q <= '0;
            hits_q     <= '0;
            hit_rate_q <= '0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CACHE_TGEN_WRITE_MIX_EN
            phase_q    <= '0;
            write_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q     <= mode;
                        stride_q   <= stride;
                        num_q      <= num_accesses;
                        // In random mode the address register is the LFSR itself.
                        if (mode == MODE_RAND)
                            addr_q <= (base_addr == '0) ? ADDR_W'(1) : base_addr;
                        else
                            addr_q <= base_addr;
                        attempts_q <= '0;
                        hits_q     <= '0;
                        hit_rate_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        read_q     <= (num_accesses != '0);
`ifdef CACHE_TGEN_WRITE_MIX_EN
                        phase_q    <= '0;
                        write_q    <= 1'b0;
`endif
                        state_q    <= (num_accesses != '0) ? ISSUE : DIVIDE;
                    end
                end
                ISSUE: begin
                    if (cache_ready) begin
                        attempts_q <= attempts_q + 1'b1;
                        hits_q     <= hits_inc;
                        addr_q     <= addr_d;
                        if (last_access) begin
                            read_q  <= 1'b0;
`ifdef CACHE_TGEN_WRITE_MIX_EN
                            write_q <= 1'b0;
`endif
                            state_q <= DIVIDE;
                        end else begin
`ifdef CACHE_TGEN_WRITE_MIX_EN
                            phase_q <= phase_d;
                            read_q  <= (phase_d != PH_LAST);
                            write_q <= (phase_d == PH_LAST);
`endif
                        end
                    end
                end
                DIVIDE: begin
                    if (attempts_q == '0 || div_done) begin
                        hit_rate_q <= (attempts_q == '0) ? '0 : div_quo;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
            endcase
        end
    end

    assign cache_read = read_q;
    assign address    = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign attempts   = attempts_q;
    assign hits       = hits_q;
    assign hit_rate   = hit_rate_q;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed self-checking bench for cache_traffic_gen; inputs change and outputs are sampled on negedge.
module tb_cache_traffic_gen;

    localparam int ADDR_W = 15;
    localparam int CNT_W  = 14;
    localparam int WE     = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  num_accesses;
    logic              cache_ready;
    logic              cache_hit;
    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] address;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  attempts;
    logic [CNT_W-1:0]  hits;
    logic [6:0]        hit_rate;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_addr [16];
    logic [15:0] hit_pat;
    int          cyc;

    cache_traffic_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .base_addr    (base_addr),
        .stride       (stride),
        .num_accesses (num_accesses),
        .cache_ready  (cache_ready),
        .cache_hit    (cache_hit),
        .cache_read   (cache_read),
        .cache_write  (cache_write),
        .address      (address),
        .busy         (busy),
        .done         (done),
        .attempts     (attempts),
        .hits         (hits),
        .hit_rate     (hit_rate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic exp_wr(input int k);
`ifdef CACHE_TGEN_WRITE_MIX_EN
        return ((k + 1) % WE) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic start_run(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                             input logic [ADDR_W-1:0] s, input logic [CNT_W-1:0] n);
        start = 1'b1;
        mode = m;
        base_addr = b;
        stride = s;
        num_accesses = n;
        cache_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic walk(input int first, input int count, input int stall_k);
        for (int k = first; k < first + count; k++) begin
            if (k == stall_k) begin
                cache_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check("stall_addr", 32'(address), exp_addr[k]);
                    check("stall_attempts", 32'(attempts), 32'(k));
                    @(negedge clk);
                end
                cache_ready = 1'b1;
            end
            check("addr", 32'(address), exp_addr[k]);
            check("read", 32'(cache_read), 32'(!exp_wr(k)));
            check("write", 32'(cache_write), 32'(exp_wr(k)));
            check("attempts", 32'(attempts), 32'(k));
            cache_hit = hit_pat[k];
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            check("divide_no_req", 32'(cache_read | cache_write), 32'd0);
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        base_addr = '0;
        stride = '0;
        num_accesses = '0;
        cache_ready = 1'b0;
        cache_hit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_req", 32'({cache_read, cache_write, busy, done}), 32'd0);
        check("rst_cnt", 32'({attempts, hits, hit_rate}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Sequential run, 6 hits of 8.
        hit_pat = 16'b0000_0000_1101_1011;
        for (int k = 0; k < 8; k++) exp_addr[k] = 32'(1024 + k);
        start_run(2'd0, 15'd1024, 15'd0, 14'd8);
        walk(0, 8, -1);
        check("seq_drop_req", 32'({cache_read, cache_write}), 32'd0);
        check("seq_busy", 32'(busy), 32'd1);
        check("seq_attempts", 32'(attempts), 32'd8);
        check("seq_hits", 32'(hits), 32'd6);
        wait_done(cyc);
        check("seq_div_cycles", 32'(cyc), 32'd21);
        check("seq_hit_rate", 32'(hit_rate), 32'd75);
        check("seq_done_busy", 32'({done, busy}), 32'b10);

        // Backpressure at access 2.
        start_run(2'd0, 15'd1024, 15'd0, 14'd8);
        check("bp_cleared", 32'(hit_rate), 32'd0);
        walk(0, 8, 2);
        check("bp_attempts", 32'(attempts), 32'd8);
        check("bp_hits", 32'(hits), 32'd6);
        wait_done(cyc);
        check("bp_div_cycles", 32'(cyc), 32'd21);
        check("bp_hit_rate", 32'(hit_rate), 32'd75);

        // Strided wrap, 1 hit of 3.
        hit_pat = 16'b010;
        exp_addr[0] = 32'h7FFE;
        exp_addr[1] = 32'h0001;
        exp_addr[2] = 32'h0004;
        start_run(2'd1, 15'h7FFE, 15'd3, 14'd3);
        walk(0, 3, -1);
        wait_done(cyc);
        check("str_hits", 32'(hits), 32'd1);
        check("str_hit_rate", 32'(hit_rate), 32'd33);

        // LFSR from a zero seed, all hits.
        hit_pat = 16'b1111;
        exp_addr[0] = 32'h0001;
        exp_addr[1] = 32'h6000;
        exp_addr[2] = 32'h3000;
        exp_addr[3] = 32'h1800;
        start_run(2'd2, 15'd0, 15'd0, 14'd4);
        walk(0, 4, -1);
        wait_done(cyc);
        check("rnd_hit_rate", 32'(hit_rate), 32'd100);

        // Zero-length run bypasses the divider.
        start_run(2'd0, 15'd55, 15'd0, 14'd0);
        check("zero_req", 32'({cache_read, cache_write}), 32'd0);
        check("zero_busy", 32'({busy, done}), 32'b10);
        check("zero_rate_clr", 32'(hit_rate), 32'd0);
        wait_done(cyc);
        check("zero_div_cycles", 32'(cyc), 32'd1);
        check("zero_result", 32'({attempts, hit_rate}), 32'd0);
        check("zero_done", 32'(done), 32'd1);

        // Reset mid-run; a start during ISSUE is ignored.
        hit_pat = 16'hFFFF;
        for (int k = 0; k < 10; k++) exp_addr[k] = 32'(16'h100 + k);
        start_run(2'd0, 15'h100, 15'd0, 14'd10);
        walk(0, 1, -1);
        start = 1'b1;
        mode = 2'd2;
        base_addr = 15'h7000;
        num_accesses = 14'd1;
        walk(1, 1, -1);
        start = 1'b0;
        walk(2, 3, -1);
        check("pre_rst_addr", 32'(address), 32'h105);
        check("pre_rst_attempts", 32'(attempts), 32'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_addr", 32'(address), 32'd0);
        check("mid_rst_flags", 32'({cache_read, cache_write, busy, done}), 32'd0);
        check("mid_rst_cnt", 32'({attempts, hits, hit_rate}), 32'd0);
        @(negedge clk);
        check("mid_rst_hold", 32'({cache_read, busy}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'({busy, done}), 32'd0);

        hit_pat = 16'b0000_0000_0000_0001;
        for (int k = 0; k < 8; k++) exp_addr[k] = 32'(1024 + k);
        start_run(2'd0, 15'd1024, 15'd0, 14'd8);
        walk(0, 8, -1);
        wait_done(cyc);
        check("post_rst_cycles", 32'(cyc), 32'd21);
        check("post_rst_hits", 32'(hits), 32'd1);
        check("post_rst_rate", 32'(hit_rate), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
- Parametrised access-pattern generator that drives the cache's read/write request interface for hit-rate characterisation runs.
- Issues a programmed number of accesses from a base address using one of three patterns: sequential, strided or pseudo-random.
- Counts its own attempts and hits. At end of run it computes the integer hit-rate percentage with a multi-cycle divider.
- Sits between the testbench/top-level control and the direct-mapped cache, replacing fixed-address, fixed-count traffic generation.

Parameters:
- ADDR_W, 15, cache address width.
- CNT_W, 14, width of the access-count, attempt and hit counters.
- LFSR_TAPS, 15'h6000, Galois LFSR feedback mask, width ADDR_W (x^15+x^14+1).
- WRITE_EVERY, 4, under CACHE_TGEN_WRITE_MIX_EN every WRITE_EVERY-th access is a write; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches config and begins a run (honoured in IDLE/DONE only)
- mode  in  2  0=sequential(+1), 1=strided(+stride), 2=LFSR random, 3=treated as sequential
- base_addr  in  ADDR_W  first address; also the LFSR seed
- stride  in  ADDR_W  address increment for mode 1
- num_accesses  in  CNT_W  accesses in the run
- cache_ready  in  1  cache completed the current request this cycle
- cache_hit  in  1  hit flag, valid only when cache_ready=1
- cache_read  out  1  read request
- cache_write  out  1  write request
- address  out  ADDR_W  request address
- busy  out  1  high in ISSUE and DIVIDE
- done  out  1  high in DONE
- attempts  out  CNT_W  completed accesses
- hits  out  CNT_W  completed hits
- hit_rate  out  7  floor(hits*100/attempts), 0..100; 0 when attempts=0

Behaviour:
- Reset values: all outputs 0, address=0, state IDLE. Reset mid-run aborts immediately; no residual request.
- All outputs are registered.
- States:
  - IDLE: wait for start.
  - ISSUE: run the access sequence.
  - DIVIDE: compute hit_rate.
  - DONE: hold results.
- start in IDLE/DONE:
  - latch mode, stride and num_accesses; address<=base_addr; attempts, hits, hit_rate <= 0.
  - LFSR <= base_addr, or 1 if base_addr==0.
  - next state: ISSUE if num_accesses≠0, else DIVIDE.
- start in ISSUE/DIVIDE: ignored.
- ISSUE:
  - Exactly one of cache_read/cache_write is high every cycle. address stays stable until a cycle with cache_ready=1.
  - On the clk edge where cache_ready=1:
    - attempts+=1; hits+=cache_hit.
    - Advance address per mode: +1, +stride, or the next LFSR state (shift right; if the shifted-out bit is 1, XOR LFSR_TAPS).
    - All address arithmetic wraps modulo 2^ADDR_W.
  - On the edge completing access num_accesses: drop both requests the next cycle and enter DIVIDE.
  - The address register advances past the last access; its value is don't-care after the run.
- DIVIDE:
  - Restoring divider (CNT_W+7)-bit dividend hits*100 ÷ attempts, one quotient bit per cycle.
  - Fixed latency CNT_W+7 cycles; then hit_rate is valid and the state becomes DONE.
  - attempts==0 bypasses the divider: hit_rate=0, DONE after 1 cycle.
- DONE: done=1; results held until the next start or reset.
- Counters cannot overflow, since attempts ≤ num_accesses < 2^CNT_W.
- cache_ready outside ISSUE is ignored.

Optional Feature:
- Macro CACHE_TGEN_WRITE_MIX_EN.
- Defined: access index k (0-based) with (k+1) % WRITE_EVERY == 0 asserts cache_write instead of cache_read. Write completions count as attempts; cache_hit on writes is counted too.
- Undefined: cache_write tied 0; all accesses are reads.

Decomposition:
- Package cache_tgen_pkg:
  - state enum {IDLE, ISSUE, DIVIDE, DONE}
  - mode constants MODE_SEQ=0, MODE_STRIDE=1, MODE_RAND=2
  - percent constant 100
- Sub-module seq_divider (parametrised dividend/divisor width; start/busy/done handshake; restoring algorithm). Instantiated once; reusable elsewhere.

Test Plan:
- Sequential run:
  - Stimulus: mode=0, base=1024, n=8, cache_ready=1 constantly, cache_hit=1 on 6 of 8.
  - Response: addresses 1024..1031 on consecutive cycles; attempts=8, hits=6; hit_rate=75 after 21 DIVIDE cycles; done=1.
- Backpressure:
  - Stimulus: as above, cache_ready low for 3 cycles at access 2.
  - Response: address holds 1026 for 4 cycles; attempts stalls at 2; final counts unchanged.
- Strided wrap:
  - Stimulus: mode=1, base=0x7FFE, stride=3, n=3.
  - Response: addresses 0x7FFE, 0x0001, 0x0004.
- Random mode:
  - Stimulus: mode=2, base=0, n=4.
  - Response: addresses 0x0001, 0x6000, 0x3000, 0x1800.
- Zero count:
  - Stimulus: n=0.
  - Response: no request ever asserted; hit_rate=0; done within 2 cycles of start.
- Reset mid-run and write mix:
  - Reset at access 5 of 10 → all outputs 0 next cycle; a later start with n=8 completes normally.
  - With CACHE_TGEN_WRITE_MIX_EN: accesses 3 and 7 are writes.
